ntt_job_master: RTL and testbench
=================================

// Module: ntt_job_master
// PURPOSE
//  Hardware initiator for the NTT_wrapper run/done protocol.
//  - Accepts one transform job (ntt_mode_t) per valid/ready handshake.
//  - Pulses run to NTT_wrapper and waits for done.
//  - Captures the 256-coefficient result (poly_t) and streams it out one 12-bit coefficient per beat.
//  - Sits between the KEM top-level control and NTT_wrapper; replaces the bench-driven run/wait(done) sequence.
// PARAMETERS
//  N_COEF       256   coefficients per polynomial; index width = $clog2(N_COEF)
//  COEF_W       12    bits per coefficient
//  TIMEOUT_CYC  4096  max WAIT cycles before the job is aborted
// PORTS
//  clk_i        in   1            clock, all logic on rising edge
//  rst_n_i      in   1            synchronous reset, active-low
//  job_valid_i  in   1            job request valid
//  job_ready_o  out  1            block can accept a job (IDLE only)
//  job_mode_i   in   ntt_mode_t   requested operation (TYPES_KEM), forwarded unchanged
//  ntt_run_o    out  1            one-cycle start pulse to NTT_wrapper run_i
//  ntt_mode_o   out  ntt_mode_t   to NTT_wrapper mode_i
//  ntt_done_i   in   1            NTT_wrapper done_o
//  ntt_poly_i   in   poly_t       NTT_wrapper poly_c_o; coef k = bits [COEF_W*k +: COEF_W]
//  coef_valid_o out  1            output coefficient valid
//  coef_ready_i in   1            downstream accepts coefficient
//  coef_data_o  out  COEF_W       coefficient value
//  coef_idx_o   out  8            index of coef_data_o, 0..N_COEF-1
//  coef_last_o  out  1            high with index N_COEF-1
//  busy_o       out  1            state != IDLE
//  timeout_o    out  1            sticky: last job aborted by timeout
// BEHAVIOUR
//  Reset (rst_n_i=0 at an edge):
//   - State -> IDLE; all outputs 0, incl. job_ready_o, ntt_mode_o, coef_idx_o, timeout_o.
//   - job_ready_o rises the first cycle after reset is released.
//   - Reset mid-job aborts immediately: no further run pulse; captured data discarded.
//  States and transitions:
//   - IDLE:   job_ready_o=1. On job_valid_i&job_ready_o: latch mode, clear timeout_o, -> ISSUE.
//   - ISSUE:  ntt_run_o=1 for exactly this cycle; -> WAIT; WAIT counter cleared.
//             ntt_mode_o = latched mode from ISSUE through WAIT; 0 in all other states.
//   - WAIT:   ntt_done_i sampled only here. done=1 -> register all N_COEF coefs of ntt_poly_i
//             into the internal buffer on that edge, idx=0, -> STREAM.
//             Otherwise increment counter; counter == TIMEOUT_CYC-1 without done
//             -> set timeout_o, -> IDLE (no output beats).
//   - STREAM: coef_valid_o=1, coef_data_o=buf[idx], coef_idx_o=idx.
//             On coef_valid_o&coef_ready_i: idx+1. Beat with idx==N_COEF-1 -> IDLE.
//  Handshake rules:
//   - coef_valid_o never drops and coef_data_o/idx never change while coef_ready_i=0.
//   - ready may be high/low arbitrarily; exactly N_COEF beats per job, in index order 0..N_COEF-1.
//   - ntt_done_i in IDLE/ISSUE/STREAM is ignored (stale done from a previous job is not consumed).
//   - job_valid_i outside IDLE is not accepted; the requester holds it.
//  Timing:
//   - Job accept at edge T -> ntt_run_o high cycle T+1.
//   - done sampled at edge D -> first coef_valid_o in cycle D+1.
//   - Full-throughput stream: N_COEF consecutive cycles.
//   - Back-to-back jobs: next job accepted in the IDLE cycle after the last beat (1 bubble).
//  Arithmetic: buffer copies bits verbatim (no reduction). idx wraps never (exit at N_COEF-1).
// TESTING
//  1 Reset held 3 cycles with job_valid_i=1
//    -> all outputs 0; job_ready_o=1 in the first cycle after release.
//  2 Job NTT_a, stub done after 10 cycles, poly coef k = k*13 mod 3329, coef_ready_i=1
//    -> single run pulse; 256 beats in 256 cycles, coef_data_o==k*13%3329; last at idx 255.
//  3 Same as 2 with coef_ready_i random 50%
//    -> data/idx stable during stalls; no missing or duplicate indices; busy_o until last beat.
//  4 Stub never raises done
//    -> timeout_o=1 exactly TIMEOUT_CYC cycles after ISSUE; no coef_valid_o; next job clears timeout_o.
//  5 Stub raises done during ISSUE and again 5 cycles later
//    -> capture on the WAIT-state done only; stale done ignored.
//    Then PWM_ab job: ntt_mode_o==PWM_ab during WAIT.
//  6 Assert rst_n_i=0 at beat 100 of STREAM
//    -> coef_valid_o=0 next cycle; after release, a new job streams from idx 0 correctly.

Source files
------------

// File: rtl/ntt_job_master.sv
// ntt_job_master: issues one NTT_wrapper run/done job per handshake and streams the captured polynomial out coefficient by coefficient
package types_kem_pkg;
   localparam int KEM_N = 256;
   localparam int KEM_W = 12;
   typedef enum logic [1:0] {NTT_a = 2'd0, NTT_b = 2'd1, INTT_c = 2'd2, PWM_ab = 2'd3} ntt_mode_t;
   typedef logic [KEM_N*KEM_W-1:0] poly_t;
endpackage

module ntt_job_master
   import types_kem_pkg::*;
#(
   parameter int N_COEF      = 256,
   parameter int COEF_W      = 12,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       job_valid_i,
   output logic                       job_ready_o,
   input  ntt_mode_t                  job_mode_i,
   output logic                       ntt_run_o,
   output ntt_mode_t                  ntt_mode_o,
   input  logic                       ntt_done_i,
   input  logic [N_COEF*COEF_W-1:0]   ntt_poly_i,
   output logic                       coef_valid_o,
   input  logic                       coef_ready_i,
   output logic [COEF_W-1:0]          coef_data_o,
   output logic [$clog2(N_COEF)-1:0]  coef_idx_o,
   output logic                       coef_last_o,
   output logic                       busy_o,
   output logic                       timeout_o
);
   localparam int IDX_W = $clog2(N_COEF);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STREAM} state_t;
   state_t                   state_q, state_d;
   ntt_mode_t                mode_q, mode_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     timeout_q, timeout_d;
   logic [N_COEF*COEF_W-1:0] buf_q;
   logic                     cap, stream, last;
   assign stream       = state_q == STREAM;
   assign last         = stream && idx_q == IDX_W'(N_COEF-1);
   // ready is gated by reset so it stays low while reset is held
   assign job_ready_o  = rst_n_i && state_q == IDLE;
   assign ntt_run_o    = state_q == ISSUE;
   assign ntt_mode_o   = (state_q == ISSUE || state_q == WAIT) ? mode_q : NTT_a;
   assign coef_valid_o = stream;
   assign coef_data_o  = stream ? buf_q[idx_q*COEF_W +: COEF_W] : '0;
   assign coef_idx_o   = stream ? idx_q : '0;
   assign coef_last_o  = last;
   assign busy_o       = state_q != IDLE;
   assign timeout_o    = timeout_q;
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         mode_q    <= NTT_a;
         cnt_q     <= '0;
         idx_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (cap) buf_q <= ntt_poly_i;
   end
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      timeout_d = timeout_q;
      cap       = 1'b0;
      case (state_q)
         IDLE: if (job_valid_i) begin
            mode_d    = job_mode_i;
            timeout_d = 1'b0;
            state_d   = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: if (ntt_done_i) begin
            cap     = 1'b1;
            idx_d   = '0;
            state_d = STREAM;
         end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
         end else cnt_d = cnt_q + 1'b1;
         STREAM: if (coef_ready_i) begin
            idx_d   = idx_q + 1'b1;
            state_d = last ? IDLE : STREAM;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ntt_job_master.sv
// tb_ntt_job_master: directed checks of job handshake, run/done, capture, streaming, timeout and reset abort
module tb_ntt_job_master;
   import types_kem_pkg::*;
   localparam int N = 256;
   localparam int W = 12;
   localparam int TO = 4096;
   logic           clk = 1'b0;
   logic           rst_n;
   logic           job_valid;
   logic           job_ready;
   ntt_mode_t      job_mode;
   logic           ntt_run;
   ntt_mode_t      ntt_mode;
   logic           ntt_done;
   logic [N*W-1:0] ntt_poly;
   logic           coef_valid;
   logic           coef_ready;
   logic [W-1:0]   coef_data;
   logic [7:0]     coef_idx;
   logic           coef_last;
   logic           busy;
   logic           timeout;
   int             n_chk = 0;
   int             n_fail = 0;
   int             n, k;
   logic           saw_valid;

   ntt_job_master #(.N_COEF(N), .COEF_W(W), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .job_valid_i(job_valid), .job_ready_o(job_ready),
      .job_mode_i(job_mode), .ntt_run_o(ntt_run), .ntt_mode_o(ntt_mode), .ntt_done_i(ntt_done),
      .ntt_poly_i(ntt_poly), .coef_valid_o(coef_valid), .coef_ready_i(coef_ready),
      .coef_data_o(coef_data), .coef_idx_o(coef_idx), .coef_last_o(coef_last),
      .busy_o(busy), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic int coef(int m, int a, int i);
      return (i*m + a) % 3329;
   endfunction

   function automatic logic [N*W-1:0] mk_poly(int m, int a);
      logic [N*W-1:0] p;
      for (int i = 0; i < N; i++) p[i*W +: W] = W'(coef(m, a, i));
      return p;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] all_out();
      return {job_ready, ntt_run, ntt_mode, coef_valid, coef_data, coef_idx, coef_last, busy, timeout};
   endfunction

   task automatic issue(ntt_mode_t m);
      job_mode = m;
      job_valid = 1'b1;
      tick();
      job_valid = 1'b0;
      chk("issue", {ntt_run, busy, job_ready, ntt_mode}, {1'b1, 1'b1, 1'b0, m});
   endtask

   task automatic wait_done(int cyc, logic [N*W-1:0] p, ntt_mode_t m);
      repeat (cyc) begin
         tick();
         chk("wait", {ntt_run, coef_valid, busy, ntt_mode}, {1'b0, 1'b0, 1'b1, m});
      end
      ntt_done = 1'b1;
      ntt_poly = p;
      tick();
      ntt_done = 1'b0;
   endtask

   task automatic stream_full(int m, int a);
      for (int i = 0; i < N; i++) begin
         chk("beat", {coef_valid, coef_last, coef_idx, coef_data}, {1'b1, i == N-1, 8'(i), W'(coef(m, a, i))});
         tick();
      end
      chk("post_stream", {coef_valid, busy, job_ready}, 3'b001);
   endtask

   initial begin
      rst_n = 1'b0;
      job_valid = 1'b1;
      job_mode = NTT_a;
      ntt_done = 1'b0;
      ntt_poly = '0;
      coef_ready = 1'b0;
      // 1: reset held with a pending job
      repeat (3) begin
         tick();
         chk("reset_outs", 32'(all_out()), 0);
      end
      rst_n = 1'b1;
      #1;
      chk("ready_after_release", {job_ready, busy}, 2'b10);
      // 2: full-throughput job
      coef_ready = 1'b1;
      issue(NTT_a);
      wait_done(10, mk_poly(13, 0), NTT_a);
      stream_full(13, 0);
      // 3: random downstream backpressure
      issue(NTT_a);
      wait_done(10, mk_poly(13, 0), NTT_a);
      k = 0;
      n = 0;
      while (k < N && n < 3000) begin
         chk("stall_beat", {coef_valid, busy, coef_idx, coef_data}, {1'b1, 1'b1, 8'(k), W'(coef(13, 0, k))});
         coef_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
         if (coef_ready) k++;
      end
      chk("stall_count", k, N);
      chk("stall_end", {coef_valid, busy}, 2'b00);
      coef_ready = 1'b1;
      // 4: done never arrives
      issue(NTT_b);
      n = 0;
      saw_valid = 1'b0;
      while (!timeout && n < 5000) begin
         tick();
         n++;
         saw_valid |= coef_valid | ntt_run;
      end
      chk("timeout_cycles", n, TO + 1);
      chk("timeout_state", {timeout, busy, job_ready, saw_valid}, 4'b1010);
      // 5: next job clears timeout; done during ISSUE is ignored
      issue(NTT_b);
      chk("timeout_cleared", timeout, 0);
      ntt_done = 1'b1;
      ntt_poly = '1;
      tick();
      ntt_done = 1'b0;
      chk("issue_done_ignored", {coef_valid, busy, ntt_mode}, {1'b0, 1'b1, NTT_b});
      ntt_poly = '0;
      wait_done(3, mk_poly(7, 100), NTT_b);
      stream_full(7, 100);
      // stale done in IDLE, then PWM_ab job
      ntt_done = 1'b1;
      issue(PWM_ab);
      ntt_done = 1'b0;
      wait_done(4, mk_poly(13, 0), PWM_ab);
      stream_full(13, 0);
      // 6: reset mid-stream
      issue(INTT_c);
      wait_done(2, mk_poly(7, 100), INTT_c);
      for (int i = 0; i < 100; i++) tick();
      chk("beat100", {coef_valid, coef_idx, coef_data}, {1'b1, 8'd100, W'(coef(7, 100, 100))});
      rst_n = 1'b0;
      tick();
      chk("reset_mid_stream", 32'(all_out()), 0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_abort", job_ready, 1);
      issue(NTT_a);
      wait_done(3, mk_poly(13, 0), NTT_a);
      stream_full(13, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
